// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - drives all 16 vectors into a 4-input function and captures its truth table
// Optional expected-table compare: define TRUTH_TABLE_SWEEPER_EXPECT_EN.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        b,
`ifdef TRUTH_TABLE_SWEEPER_EXPECT_EN
  input  logic [15:0] expected,
  output logic        mismatch,
  output logic [3:0]  mismatch_idx,
`endif
  output logic        x1,
  output logic        y1,
  output logic        x2,
  output logic        y2,
  output logic        busy,
  output logic        done,
  output logic        table_valid,
  output logic [15:0] truth_table,
  output logic [4:0]  ones_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  settle_q, settle_d;
  logic [3:0]  vec_q, vec_d;
  logic [15:0] table_q, table_d;
  logic [4:0]  ones_q, ones_d;
  logic        valid_q, valid_d;
  logic        start_acc;
  logic        sample;
  logic        last_vec;

`ifdef TRUTH_TABLE_SWEEPER_EXPECT_EN
  logic [15:0] exp_q, exp_d;
  logic        mm_q, mm_d;
  logic [3:0]  mmi_q, mmi_d;
  logic [15:0] diff;
`endif

  // abort dominates both start in IDLE and the sample edge in RUN
  assign start_acc = (state_q == S_IDLE) && start && !abort;
  assign sample    = (state_q == S_RUN) && !abort && (settle_q == LAST_SETTLE);
  assign last_vec  = (idx_q == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_acc) state_d = S_RUN;
      S_RUN: begin
        if (abort)                   state_d = S_IDLE;
        else if (sample && last_vec) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    {x1, y1, x2, y2} = vec_q;
    table_valid = valid_q;
    truth_table = table_q;
    ones_count  = ones_q;
`ifdef TRUTH_TABLE_SWEEPER_EXPECT_EN
    mismatch     = mm_q;
    mismatch_idx = mmi_q;
`endif
  end

  always_comb begin
    idx_d    = idx_q;
    settle_d = settle_q;
    vec_d    = vec_q;
    table_d  = table_q;
    ones_d   = ones_q;
    valid_d  = valid_q;
`ifdef TRUTH_TABLE_SWEEPER_EXPECT_EN
    exp_d = exp_q;
    mm_d  = mm_q;
    mmi_d = mmi_q;
    diff  = '0;
`endif
    if (start_acc) begin
      idx_d    = '0;
      settle_d = '0;
      vec_d    = '0;
      table_d  = '0;
      ones_d   = '0;
      valid_d  = 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_EXPECT_EN
      exp_d = expected;
      mm_d  = 1'b0;
      mmi_d = '0;
`endif
    end else if (state_q == S_RUN) begin
      if (abort) begin
        idx_d    = '0;
        settle_d = '0;
        vec_d    = '0;
      end else if (sample) begin
        table_d[idx_q] = b;
        ones_d         = ones_q + {4'd0, b};
        settle_d       = '0;
        if (last_vec) begin
          idx_d   = '0;
          vec_d   = '0;
          valid_d = 1'b1;
`ifdef TRUTH_TABLE_SWEEPER_EXPECT_EN
          diff = table_d ^ exp_q;
          mm_d = |diff;
          mmi_d = '0;
          for (int i = 15; i >= 0; i--) begin
            if (diff[i]) mmi_d = 4'(i);
          end
`endif
        end else begin
          idx_d = idx_q + 4'd1;
          vec_d = idx_q + 4'd1;
        end
      end else begin
        settle_d = settle_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      settle_q <= '0;
      vec_q    <= '0;
      table_q  <= '0;
      ones_q   <= '0;
      valid_q  <= 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_EXPECT_EN
      exp_q <= '0;
      mm_q  <= 1'b0;
      mmi_q <= '0;
`endif
    end else begin
      idx_q    <= idx_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      table_q  <= table_d;
      ones_q   <= ones_d;
      valid_q  <= valid_d;
`ifdef TRUTH_TABLE_SWEEPER_EXPECT_EN
      exp_q <= exp_d;
      mm_q  <= mm_d;
      mmi_q <= mmi_d;
`endif
    end
  end

endmodule
